// File: rtl/dual_port_ram_ctrl.sv
// Two-client arbiter in front of a dual-port RAM: accepts requests, issues registered
// RAM controls one cycle later, and returns a one-cycle response strobe two cycles after accept.
module dual_port_ram_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_wr_en,
  output logic              ram_port_en_0,
  output logic              ram_port_en_1,
  output logic [ADDR_W-1:0] ram_addr_0,
  output logic [ADDR_W-1:0] ram_addr_1,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out_0,
  input  logic [DATA_W-1:0] ram_data_out_1,
  output logic [7:0]        conflict_cnt
);

  logic              conflict, grant_a, grant_b, same_rd;

  logic              wr_en_q, wr_en_d;
  logic              port_en_0_q, port_en_0_d;
  logic              port_en_1_q, port_en_1_d;
  logic [ADDR_W-1:0] addr_0_q, addr_0_d;
  logic [ADDR_W-1:0] addr_1_q, addr_1_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;

  logic              iss_a_q, iss_a_d;
  logic              iss_a_we_q, iss_a_we_d;
  logic              iss_b_q, iss_b_d;
  logic              iss_b_we_q, iss_b_we_d;
  logic              iss_b_p0_q, iss_b_p0_d;

  logic              a_rsp_q, a_rsp_d;
  logic              b_rsp_q, b_rsp_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic              rr_q, rr_d;
  logic [7:0]        cnt_q, cnt_d;

  always_comb begin
    conflict = a_valid & b_valid & (a_we | b_we);
    // rr_q = 0 favours A, 1 favours B; only consulted on a conflict
    grant_a  = a_valid & (~conflict | ~rr_q);
    grant_b  = b_valid & (~conflict | rr_q);
    // Both grants without a conflict means both are reads
    same_rd  = grant_a & grant_b & (a_addr == b_addr);
    a_ready  = ~rst & grant_a;
    b_ready  = ~rst & grant_b;
  end

  always_comb begin
    wr_en_d     = (grant_a & a_we) | (grant_b & b_we);
    port_en_0_d = grant_a;
    port_en_1_d = grant_b & ~same_rd;
    addr_0_d    = grant_a ? a_addr : addr_0_q;
    addr_1_d    = port_en_1_d ? b_addr : addr_1_q;
    data_in_d   = data_in_q;
    if (grant_a && a_we)
      data_in_d = a_wdata;
    else if (grant_b && b_we)
      data_in_d = b_wdata;

    iss_a_d    = grant_a;
    iss_a_we_d = a_we;
    iss_b_d    = grant_b;
    iss_b_we_d = b_we;
    iss_b_p0_d = same_rd;

    // Read data is taken only from a port enabled in the issue cycle
    a_rsp_d   = iss_a_q;
    a_rdata_d = '0;
    if (iss_a_q && !iss_a_we_q && port_en_0_q)
      a_rdata_d = ram_data_out_0;

    b_rsp_d   = iss_b_q;
    b_rdata_d = '0;
    if (iss_b_q && !iss_b_we_q) begin
      if (iss_b_p0_q && port_en_0_q)
        b_rdata_d = ram_data_out_0;
      else if (!iss_b_p0_q && port_en_1_q)
        b_rdata_d = ram_data_out_1;
    end

    rr_d  = conflict ? ~rr_q : rr_q;
    cnt_d = cnt_q;
    if (conflict && cnt_q != 8'd255)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q     <= 1'b0;
      port_en_0_q <= 1'b0;
      port_en_1_q <= 1'b0;
      addr_0_q    <= '0;
      addr_1_q    <= '0;
      data_in_q   <= '0;
      iss_a_q     <= 1'b0;
      iss_a_we_q  <= 1'b0;
      iss_b_q     <= 1'b0;
      iss_b_we_q  <= 1'b0;
      iss_b_p0_q  <= 1'b0;
      a_rsp_q     <= 1'b0;
      b_rsp_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      wr_en_q     <= wr_en_d;
      port_en_0_q <= port_en_0_d;
      port_en_1_q <= port_en_1_d;
      addr_0_q    <= addr_0_d;
      addr_1_q    <= addr_1_d;
      data_in_q   <= data_in_d;
      iss_a_q     <= iss_a_d;
      iss_a_we_q  <= iss_a_we_d;
      iss_b_q     <= iss_b_d;
      iss_b_we_q  <= iss_b_we_d;
      iss_b_p0_q  <= iss_b_p0_d;
      a_rsp_q     <= a_rsp_d;
      b_rsp_q     <= b_rsp_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram_wr_en     = wr_en_q;
  assign ram_port_en_0 = port_en_0_q;
  assign ram_port_en_1 = port_en_1_q;
  assign ram_addr_0    = addr_0_q;
  assign ram_addr_1    = addr_1_q;
  assign ram_data_in   = data_in_q;
  assign a_rsp_valid   = a_rsp_q;
  assign b_rsp_valid   = b_rsp_q;
  assign a_rdata       = a_rdata_q;
  assign b_rdata       = b_rdata_q;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Directed bench for dual_port_ram_ctrl with a behavioural 16x8 RAM attached.
module tb_dual_port_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_ready, a_we, a_rsp_valid;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_valid, b_ready, b_we, b_rsp_valid;
  logic [3:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       ram_wr_en, ram_port_en_0, ram_port_en_1;
  logic [3:0] ram_addr_0, ram_addr_1;
  logic [7:0] ram_data_in, ram_data_out_0, ram_data_out_1;
  logic [7:0] conflict_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  dual_port_ram_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .ram_wr_en(ram_wr_en), .ram_port_en_0(ram_port_en_0), .ram_port_en_1(ram_port_en_1),
    .ram_addr_0(ram_addr_0), .ram_addr_1(ram_addr_1), .ram_data_in(ram_data_in),
    .ram_data_out_0(ram_data_out_0), .ram_data_out_1(ram_data_out_1),
    .conflict_cnt(conflict_cnt)
  );

  // RAM model: synchronous write, combinational read, garbage on a disabled port
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_wr_en && ram_port_en_0) mem[ram_addr_0] <= ram_data_in;
    if (ram_wr_en && ram_port_en_1) mem[ram_addr_1] <= ram_data_in;
  end
  assign ram_data_out_0 = ram_port_en_0 ? mem[ram_addr_0] : 8'hEE;
  assign ram_data_out_1 = ram_port_en_1 ? mem[ram_addr_1] : 8'hEE;

  typedef struct {
    logic       av, awe; logic [3:0] aad; logic [7:0] awd;
    logic       bv, bwe; logic [3:0] bad; logic [7:0] bwd;
    logic       e_ar, e_br, e_we, e_en0, e_en1;
    logic [3:0] e_ad0, e_ad1; logic [7:0] e_din;
    logic       e_arv; logic [7:0] e_ard;
    logic       e_brv; logic [7:0] e_brd;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {30'd0, a_ready, b_ready}, 32'd0);
    chk({tag, "_rsp"}, {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, a_rdata, b_rdata}, 32'd0);
    chk({tag, "_ramctl"}, {29'd0, ram_wr_en, ram_port_en_0, ram_port_en_1}, 32'd0);
    chk({tag, "_ramaddr"}, {24'd0, ram_addr_0, ram_addr_1}, 32'd0);
    chk({tag, "_din"}, {24'd0, ram_data_in}, 32'd0);
    chk({tag, "_cnt"}, {24'd0, conflict_cnt}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1,1,4'h3,8'hA5, 0,0,4'h0,8'h00, 1,0, 1,1,0, 4'h3,4'h0,8'hA5, 1,8'h00, 0,8'h00, 8'd0};
    vecs[1]  = '{0,0,4'h0,8'h00, 1,1,4'h7,8'h11, 0,1, 1,0,1, 4'h3,4'h7,8'h11, 0,8'h00, 1,8'h00, 8'd0};
    vecs[2]  = '{1,0,4'h3,8'h00, 1,0,4'h7,8'h00, 1,1, 0,1,1, 4'h3,4'h7,8'h11, 1,8'hA5, 1,8'h11, 8'd0};
    vecs[3]  = '{0,0,4'h0,8'h00, 1,1,4'h5,8'h3C, 0,1, 1,0,1, 4'h3,4'h5,8'h3C, 0,8'h00, 1,8'h00, 8'd0};
    vecs[4]  = '{1,0,4'h5,8'h00, 1,0,4'h5,8'h00, 1,1, 0,1,0, 4'h5,4'h5,8'h3C, 1,8'h3C, 1,8'h3C, 8'd0};
    vecs[5]  = '{1,1,4'h2,8'h77, 1,0,4'h2,8'h00, 1,0, 1,1,0, 4'h2,4'h5,8'h77, 1,8'h00, 0,8'h00, 8'd1};
    vecs[6]  = '{0,0,4'h0,8'h00, 1,0,4'h2,8'h00, 0,1, 0,0,1, 4'h2,4'h2,8'h77, 0,8'h00, 1,8'h77, 8'd1};
    vecs[7]  = '{1,1,4'h2,8'h99, 1,0,4'h2,8'h00, 0,1, 0,0,1, 4'h2,4'h2,8'h77, 0,8'h00, 1,8'h77, 8'd2};
    vecs[8]  = '{1,0,4'h2,8'h00, 0,0,4'h0,8'h00, 1,0, 0,1,0, 4'h2,4'h2,8'h77, 1,8'h77, 0,8'h00, 8'd2};
    vecs[9]  = '{1,1,4'h9,8'hC3, 1,1,4'h9,8'h5A, 1,0, 1,1,0, 4'h9,4'h2,8'hC3, 1,8'h00, 0,8'h00, 8'd3};
    vecs[10] = '{1,0,4'h9,8'h00, 1,0,4'hF,8'h00, 1,1, 0,1,1, 4'h9,4'hF,8'hC3, 1,8'hC3, 1,8'h00, 8'd3};

    // Reset with requests pending: nothing may be accepted
    rst = 1'b1;
    idle_inputs();
    a_valid = 1; a_we = 1; a_addr = 4'h4; a_wdata = 8'h42;
    b_valid = 1; b_addr = 4'h6;
    tick();
    tick();
    chk_reset_outputs("rst_init");
    rst = 1'b0;
    idle_inputs();
    tick();

    for (int i = 0; i < 11; i++) begin
      a_valid = vecs[i].av; a_we = vecs[i].awe; a_addr = vecs[i].aad; a_wdata = vecs[i].awd;
      b_valid = vecs[i].bv; b_we = vecs[i].bwe; b_addr = vecs[i].bad; b_wdata = vecs[i].bwd;
      #1;
      chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].e_ar});
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].e_br});
      tick();
      idle_inputs();
      chk($sformatf("v%0d_ramctl", i), {29'd0, ram_wr_en, ram_port_en_0, ram_port_en_1},
          {29'd0, vecs[i].e_we, vecs[i].e_en0, vecs[i].e_en1});
      chk($sformatf("v%0d_ramaddr", i), {24'd0, ram_addr_0, ram_addr_1},
          {24'd0, vecs[i].e_ad0, vecs[i].e_ad1});
      chk($sformatf("v%0d_din", i), {24'd0, ram_data_in}, {24'd0, vecs[i].e_din});
      tick();
      chk($sformatf("v%0d_a_rsp", i), {23'd0, a_rsp_valid, a_rdata}, {23'd0, vecs[i].e_arv, vecs[i].e_ard});
      chk($sformatf("v%0d_b_rsp", i), {23'd0, b_rsp_valid, b_rdata}, {23'd0, vecs[i].e_brv, vecs[i].e_brd});
      chk($sformatf("v%0d_idle_ctl", i), {29'd0, ram_wr_en, ram_port_en_0, ram_port_en_1}, 32'd0);
      chk($sformatf("v%0d_idle_addr", i), {24'd0, ram_addr_0, ram_addr_1},
          {24'd0, vecs[i].e_ad0, vecs[i].e_ad1});
      chk($sformatf("v%0d_cnt", i), {24'd0, conflict_cnt}, {24'd0, vecs[i].e_cnt});
      tick();
      chk($sformatf("v%0d_rsp_one_cycle", i), {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    end

    // Write-then-read to the same address, back to back through a conflict
    do_reset();
    a_valid = 1; a_we = 1; a_addr = 4'h2; a_wdata = 8'h5E;
    b_valid = 1; b_we = 0; b_addr = 4'h2;
    #1;
    chk("wr_rd_c0_ready", {30'd0, a_ready, b_ready}, 32'd2);
    tick();
    a_valid = 0; a_we = 0;
    #1;
    chk("wr_rd_c1_ready", {30'd0, a_ready, b_ready}, 32'd1);
    chk("wr_rd_c1_cnt", {24'd0, conflict_cnt}, 32'd1);
    tick();
    idle_inputs();
    chk("wr_rd_c2_a_rsp", {23'd0, a_rsp_valid, a_rdata}, {23'd0, 1'b1, 8'h00});
    chk("wr_rd_c2_b_rsp", {31'd0, b_rsp_valid}, 32'd0);
    tick();
    chk("wr_rd_c3_b_rsp", {23'd0, b_rsp_valid, b_rdata}, {23'd0, 1'b1, 8'h5E});
    // Same conflict again: B now has priority
    a_valid = 1; a_we = 1; a_addr = 4'h2; a_wdata = 8'h66;
    b_valid = 1; b_we = 0; b_addr = 4'h2;
    #1;
    chk("wr_rd_rep_ready", {30'd0, a_ready, b_ready}, 32'd1);
    tick();
    idle_inputs();
    tick();
    chk("wr_rd_rep_b_rsp", {23'd0, b_rsp_valid, b_rdata}, {23'd0, 1'b1, 8'h5E});
    chk("wr_rd_rep_cnt", {24'd0, conflict_cnt}, 32'd2);
    tick();

    // 300 consecutive conflicts: alternating grants, saturating counter
    do_reset();
    a_valid = 1; a_we = 1; a_addr = 4'hA; a_wdata = 8'h01;
    b_valid = 1; b_we = 1; b_addr = 4'hB; b_wdata = 8'h02;
    #1;
    for (int i = 0; i < 300; i++) begin
      logic exp_a;
      exp_a = (i % 2 == 0);
      chk($sformatf("sat_grant_%0d", i), {30'd0, a_ready, b_ready}, {30'd0, exp_a, ~exp_a});
      chk($sformatf("sat_cnt_%0d", i), {24'd0, conflict_cnt}, (i > 255) ? 32'd255 : i);
      tick();
    end
    idle_inputs();
    chk("sat_cnt_final", {24'd0, conflict_cnt}, 32'd255);
    tick();
    tick();
    chk("sat_cnt_hold", {24'd0, conflict_cnt}, 32'd255);

    // Reset pulsed the cycle after a read is accepted
    do_reset();
    a_valid = 1; a_we = 0; a_addr = 4'h3;
    #1;
    chk("midrst_accept", {31'd0, a_ready}, 32'd1);
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("midrst_issue_en0", {31'd0, ram_port_en_0}, 32'd1);
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst_post");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_no_rsp_%0d", i), {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dual_port_ram_ctrl.md
DUAL_PORT_RAM_CTRL -- requirements
Module: dual_port_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning RAM address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning RAM word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports a_valid/b_valid  input  1  client A/B request valid.
REQ-006 SHALL have ports a_ready/b_ready  output  1  client A/B request accepted this cycle.
REQ-007 SHALL have ports a_we/b_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr/b_addr  input  ADDR_W  request address.
REQ-009 SHALL have ports a_wdata/b_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports a_rsp_valid/b_rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have ports a_rdata/b_rdata  output  DATA_W  read data, valid with rsp_valid; 0 for writes.
REQ-012 SHALL have ports ram_wr_en, ram_port_en_0, ram_port_en_1  output  1  RAM controls.
REQ-013 SHALL have ports ram_addr_0, ram_addr_1  output  ADDR_W; ram_data_in  output  DATA_W.
REQ-014 SHALL have ports ram_data_out_0, ram_data_out_1  input  DATA_W  RAM combinational read data (Z when port disabled).
REQ-015 SHALL have port conflict_cnt  output  8  saturating count of serialized conflicts.

Function
REQ-016 Handshake: request accepted when valid && ready; client holds valid/we/addr/wdata stable until accepted; ready may depend combinationally on same-cycle valid inputs.
REQ-017 Pipeline: request accepted in cycle N drives registered RAM outputs in N+1; controller samples ram_data_out in N+1; rsp_valid/rdata asserted in N+2 for exactly one cycle.
REQ-018 Only one client valid: accept it; it uses port 0 (A) or port 1 (B).
REQ-019 Both valid, both reads, different addresses: accept both; A on port 0, B on port 1, ram_wr_en=0.
REQ-020 Both valid, both reads, same address: accept both; enable port 0 only; both responses carry ram_data_out_0; port 1 never enabled at same address as port 0.
REQ-021 Both valid, either is a write: conflict; accept only the round-robin winner; loser's ready=0; winner alone drives RAM.
REQ-022 Write issue: ram_wr_en=1, only winner's port enabled, ram_data_in=winner wdata, other port_en=0 (so no read shares a write cycle).
REQ-023 Round-robin pointer (1 bit, A priority at reset) SHALL toggle to favor the loser after each conflict, and be unchanged otherwise.
REQ-024 conflict_cnt SHALL increment once per REQ-021 conflict cycle, saturating at 255.
REQ-025 Idle cycle: ram_port_en_0/1=0, ram_wr_en=0; ram_addr/ram_data_in hold last value.
REQ-026 Ordering: a read accepted after a write to the same address (either client) SHALL return the written data.
REQ-027 rdata SHALL be sampled only from ports the controller enabled in that cycle; Z never propagated.

Reset
REQ-028 While rst=1: a_ready=b_ready=0, rsp_valid=0, rdata=0, all ram_* outputs 0, pointer=A, conflict_cnt=0.
REQ-029 Reset asserted mid-operation SHALL discard in-flight issue/response stages; no rsp_valid in the cycle after rst deasserts.

Verification
REQ-030 A write 0x3->0xA5 alone -> a_ready=1, next cycle ram_wr_en=1, port_en_0=1, addr_0=3, data_in=0xA5; a_rsp_valid 2 cycles after accept, a_rdata=0.
REQ-031 A read 0x3 and B read 0x7 same cycle (mem[3]=0xA5, mem[7]=0x11) -> both accepted; port_en_0=port_en_1=1; a_rdata=0xA5, b_rdata=0x11.
REQ-032 A and B both read 0x5 (mem=0x3C) -> port_en_1=0; both rsp_valid with 0x3C; conflict_cnt unchanged.
REQ-033 A write 0x2=0x77 and B read 0x2 same cycle after reset -> A wins, B ready=0; next cycle B accepted; b_rdata=0x77; conflict_cnt=1; repeat -> B wins.
REQ-034 300 back-to-back conflicting cycles -> conflict_cnt saturates at 255; grants alternate A,B,A,B.
REQ-035 rst pulsed one cycle after accepting a read -> no rsp_valid afterwards; all outputs at reset values.
